// File: rtl/mult_seq_ctrl_if.sv
// mult_seq_ctrl_if
//  Host-side bundle for the sequential multiplier.
//  Handshake: the host raises start with operands a/b valid in the same cycle;
//  the request is taken on the next rising edge only if busy=0 at that time
//  (IDLE or DONE). A start seen while busy=1 is dropped, never queued.
//  done is a one-cycle pulse meaning p now holds the new product.
//  Signals:
//   start  host -> ctrl  request a multiply
//   a, b   host -> ctrl  unsigned operands, WIDTH bits each
//   busy   ctrl -> host  iterating
//   done   ctrl -> host  product-ready pulse
//   p      ctrl -> host  product register, 2*WIDTH bits
//  Modports: master (host side), slave (multiplier side).
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 3
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//  Shift-and-add unsigned multiplier: one 2*WIDTH-bit adder reused over
//  WIDTH cycles. FSM IDLE -> RUN -> DONE, with DONE able to accept a new
//  request directly so back-to-back products come every WIDTH+1 cycles.
//  Optional build macro: MULT_SEQ_EARLY_EXIT_EN -- when defined, RUN ends as
//  soon as no set multiplier bits remain (minimum one iteration).
//  Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (aborts any operation, clears p)
//   bus        mult_seq_ctrl_if.slave: start/a/b in, busy/done/p out
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE)
module mult_seq_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  mult_seq_ctrl_if.slave     bus,
  output logic [1:0]         dbg_state
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [PW-1:0]     acc;
  logic [CW-1:0]     cnt;

  logic [PW-1:0]     acc_next;
  logic [WIDTH-1:0]  mplier_rest;
  logic              last_iter;

  // Partial-product add for the current multiplier LSB. The product of two
  // WIDTH-bit operands fits in PW bits, so the sum never wraps.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + mcand;
    end
  end

  assign mplier_rest = mplier >> 1;

  always_comb begin
    last_iter = (cnt == LAST_CNT);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    // No set bits left above the one consumed this edge: nothing more to add.
    if (mplier_rest == '0) begin
      last_iter = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.p    <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            mcand    <= {{WIDTH{1'b0}}, bus.a};
            mplier   <= bus.b;
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // start is ignored here; only the iteration advances.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_rest;
          cnt    <= cnt + CW'(1);
          if (last_iter) begin
            bus.p    <= acc_next;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            // Accept the next request without an IDLE bubble.
            mcand    <= {{WIDTH{1'b0}}, bus.a};
            mplier   <= bus.b;
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl
//  Bench for mult_seq_ctrl at WIDTH=3. The reference model is plain
//  arithmetic: product = a*b, iteration count from the highest set bit of b
//  (or WIDTH), done seen iters+1 cycles after the start cycle.
module tb_mult_seq_ctrl;
  localparam int W  = 3;
  localparam int PW = 2 * W;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  mult_seq_ctrl_if #(.WIDTH(W)) bus_if ();

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .dbg_state (dbg_state)
  );

  int total;
  int bad;
  logic [PW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int exp_iters(input int bv);
`ifdef MULT_SEQ_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < W; i++) begin
      if ((bv >> i) & 1) h = i + 1;
    end
    return (h == 0) ? 1 : h;
`else
    return W;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Present a request in the current cycle; returns in cycle 1 (first cycle
  // after the accepting edge) with operands scrambled to prove they are latched.
  task automatic issue(input int av, input int bv);
    bus_if.start = 1'b1;
    bus_if.a     = W'(av);
    bus_if.b     = W'(bv);
    exp_q.push_back(PW'(av * bv));
    step();
    bus_if.start = 1'b0;
    bus_if.a     = W'($urandom);
    bus_if.b     = W'($urandom);
  endtask

  // Advance until done is seen (bounded). n is the cycle index at which done
  // was observed; busy_n counts busy cycles seen on the way.
  task automatic wait_done(input int n0, output int n, output int busy_n);
    n = n0;
    busy_n = 0;
    while (bus_if.done !== 1'b1 && n < 64) begin
      if (bus_if.busy === 1'b1) busy_n++;
      step();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a = '0;
    bus_if.b = '0;
    repeat (3) step();
    total++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.p !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b p=%0d want 0 0 0",
               bus_if.busy, bus_if.done, bus_if.p);
    end
    rst = 1'b0;
    step();
    total++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: busy=%b done=%b want 0 0", bus_if.busy, bus_if.done);
    end
  endtask

  task automatic test_basic();
    int it;
    logic [PW-1:0] e;
    it = exp_iters(2);
    issue(2, 2);
    e = exp_q.pop_front();
    for (int c = 1; c <= it; c++) begin
      total++;
      if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0 || bus_if.p !== '0) begin
        bad++;
        $display("FAIL basic_run c=%0d: busy=%b done=%b p=%0d want 1 0 0",
                 c, bus_if.busy, bus_if.done, bus_if.p);
      end
      step();
    end
    total++;
    if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0 || bus_if.p !== e) begin
      bad++;
      $display("FAIL basic_done: done=%b busy=%b p=%0d want 1 0 %0d",
               bus_if.done, bus_if.busy, bus_if.p, e);
    end
    step();
    total++;
    if (bus_if.done !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.p !== e) begin
      bad++;
      $display("FAIL basic_after: done=%b busy=%b p=%0d want 0 0 %0d",
               bus_if.done, bus_if.busy, bus_if.p, e);
    end
  endtask

  task automatic test_back_to_back();
    int n, bn;
    logic [PW-1:0] e;
    issue(1, 5);
    wait_done(1, n, bn);
    e = exp_q.pop_front();
    total++;
    if (bus_if.p !== e || n != exp_iters(5) + 1) begin
      bad++;
      $display("FAIL b2b_first: p=%0d cyc=%0d want %0d %0d", bus_if.p, n, e, exp_iters(5) + 1);
    end
    issue(3, 7);  // presented in the DONE cycle
    total++;
    if (bus_if.busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_no_gap: busy=%b want 1", bus_if.busy);
    end
    wait_done(1, n, bn);
    e = exp_q.pop_front();
    total++;
    if (bus_if.p !== e || n != exp_iters(7) + 1 || bn != exp_iters(7)) begin
      bad++;
      $display("FAIL b2b_second: p=%0d spacing=%0d busy=%0d want %0d %0d %0d",
               bus_if.p, n, bn, e, exp_iters(7) + 1, exp_iters(7));
    end
  endtask

  task automatic test_sweep();
    int n, bn;
    logic [PW-1:0] e;
    int errs;
    errs = 0;
    for (int av = 0; av < (1 << W); av++) begin
      for (int bv = 0; bv < (1 << W); bv++) begin
        issue(av, bv);
        wait_done(1, n, bn);
        e = exp_q.pop_front();
        total++;
        if (bus_if.p !== e || n != exp_iters(bv) + 1 || bn != exp_iters(bv)) begin
          bad++;
          $display("FAIL sweep %0d*%0d: p=%0d cyc=%0d busy=%0d want %0d %0d %0d",
                   av, bv, bus_if.p, n, bn, e, exp_iters(bv) + 1, exp_iters(bv));
        end
        step();
      end
    end
  endtask

  task automatic test_start_ignored();
    int n, bn, extra;
    logic [PW-1:0] e;
    issue(7, 7);
    bus_if.start = 1'b1;  // cycle 1 is RUN: must be dropped
    bus_if.a = 3'd1;
    bus_if.b = 3'd1;
    step();
    bus_if.start = 1'b0;
    wait_done(2, n, bn);
    e = exp_q.pop_front();
    total++;
    if (bus_if.p !== e || n != exp_iters(7) + 1) begin
      bad++;
      $display("FAIL ignored_prod: p=%0d cyc=%0d want %0d %0d", bus_if.p, n, e, exp_iters(7) + 1);
    end
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignored_queued: extra activity cycles=%0d want 0", extra);
    end
  endtask

  task automatic test_reset_mid();
    int n, bn, seen;
    logic [PW-1:0] e;
    issue(3, 3);
    wait_done(1, n, bn);
    e = exp_q.pop_front();
    total++;
    if (bus_if.p !== e) begin
      bad++;
      $display("FAIL rstmid_pre: p=%0d want %0d", bus_if.p, e);
    end
    issue(5, 5);
    void'(exp_q.pop_back());  // this one is aborted
    step();                   // 2nd RUN cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.p !== '0) begin
      bad++;
      $display("FAIL rstmid: busy=%b done=%b p=%0d want 0 0 0",
               bus_if.busy, bus_if.done, bus_if.p);
    end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus_if.done === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rstmid_nodone: done pulses=%0d want 0", seen);
    end
  endtask

  task automatic test_latency_edges();
    int n, bn;
    logic [PW-1:0] e;
    int bl[3];
    int al[3];
    int lat[3];
    al = '{6, 5, 3};
    bl = '{1, 0, 4};
`ifdef MULT_SEQ_EARLY_EXIT_EN
    lat = '{2, 2, W + 1};
`else
    lat = '{W + 1, W + 1, W + 1};
`endif
    for (int i = 0; i < 3; i++) begin
      issue(al[i], bl[i]);
      wait_done(1, n, bn);
      e = exp_q.pop_front();
      total++;
      if (bus_if.p !== e || n != lat[i]) begin
        bad++;
        $display("FAIL latency a=%0d b=%0d: p=%0d cyc=%0d want %0d %0d",
                 al[i], bl[i], bus_if.p, n, e, lat[i]);
      end
      step();
    end
  endtask

  task automatic test_random();
    int n, bn, av, bv, gap;
    logic [PW-1:0] e;
    for (int k = 0; k < 40; k++) begin
      av = $urandom_range(0, (1 << W) - 1);
      bv = $urandom_range(0, (1 << W) - 1);
      issue(av, bv);
      wait_done(1, n, bn);
      e = exp_q.pop_front();
      total++;
      if (bus_if.p !== e || n != exp_iters(bv) + 1) begin
        bad++;
        $display("FAIL random %0d*%0d: p=%0d cyc=%0d want %0d %0d",
                 av, bv, bus_if.p, n, e, exp_iters(bv) + 1);
      end
      gap = $urandom_range(0, 2);  // 0 = next request issued from DONE
      for (int g = 0; g < gap; g++) step();
    end
    step();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_sweep();
    test_start_ignored();
    test_reset_mid();
    test_latency_edges();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
